adsr_envelope: RTL



---
 rtl/adsr_envelope_if.sv | 26 ++
 rtl/adsr_envelope.sv | 127 ++++++++++++
 2 files changed

// File: rtl/adsr_envelope_if.sv
// Control/level bundle between the note logic, one envelope voice and the synthesizer.
// The note logic drives the rates and the gate, and the envelope returns the volume.
interface adsr_envelope_if #(
  parameter int FRAC_BITS = 16
);
  logic                   sample_tick_in;
  logic                   gate_in;
  logic [FRAC_BITS+8:0]   attack_rate_in;
  logic [FRAC_BITS+8:0]   decay_rate_in;
  logic [8:0]             sustain_level_in;
  logic [FRAC_BITS+8:0]   release_rate_in;
  logic [8:0]             vol_out;
  logic                   active_out;

  modport master (
    output sample_tick_in, gate_in, attack_rate_in, decay_rate_in,
           sustain_level_in, release_rate_in,
    input  vol_out, active_out
  );

  modport slave (
    input  sample_tick_in, gate_in, attack_rate_in, decay_rate_in,
           sustain_level_in, release_rate_in,
    output vol_out, active_out
  );
endinterface

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope generator. It keeps a Q9.FRAC_BITS level that advances on each
// sample tick, and it exposes the integer part of that level as the synthesizer volume.
module adsr_envelope #(
  parameter int FRAC_BITS = 16,
  parameter int MAX_LEVEL = 256
) (
  input  logic              clk_in,
  input  logic              rst_in,
  adsr_envelope_if.slave    env
);

  localparam int LW = FRAC_BITS + 9;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ATTACK  = 3'd1;
  localparam logic [2:0] ST_DECAY   = 3'd2;
  localparam logic [2:0] ST_SUSTAIN = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  localparam logic [8:0]  MAX_VOL = 9'(MAX_LEVEL);
  localparam logic [LW:0] PEAK_X  = {1'b0, MAX_VOL, {FRAC_BITS{1'b0}}};

  logic [2:0]    state_q, state_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic          gate_q, gate_d;
  logic          gate_prev_q, gate_prev_d;
  logic          active_q, active_d;

  logic          gate_rise;
  logic          gate_fall;
  logic [8:0]    sus_clamped;
  logic [LW:0]   lvl_x;
  logic [LW:0]   sus_x;
  logic [LW:0]   attack_sum;
  logic [LW:0]   decay_floor;

  // Every level compare is done one bit wider, so that a sum can never wrap.
  always_comb begin
    gate_rise   = gate_q & ~gate_prev_q;
    gate_fall   = ~gate_q & gate_prev_q;
    sus_clamped = (env.sustain_level_in > MAX_VOL) ? MAX_VOL : env.sustain_level_in;
    lvl_x       = {1'b0, lvl_q};
    sus_x       = {1'b0, sus_clamped, {FRAC_BITS{1'b0}}};
    attack_sum  = lvl_x + {1'b0, env.attack_rate_in};
    decay_floor = sus_x + {1'b0, env.decay_rate_in};
  end

  // A pending gate edge wins over a tick, so the new state's arithmetic starts on the next tick.
  always_comb begin
    state_d     = state_q;
    lvl_d       = lvl_q;
    gate_d      = env.gate_in;
    gate_prev_d = gate_q;

    if (gate_rise) begin
      state_d = ST_ATTACK;
    end else if (gate_fall && (state_q == ST_ATTACK || state_q == ST_DECAY ||
                               state_q == ST_SUSTAIN)) begin
      state_d = ST_RELEASE;
    end else if (env.sample_tick_in) begin
      case (state_q)
        ST_IDLE: begin
          lvl_d = '0;
        end
        ST_ATTACK: begin
          if (env.attack_rate_in == '0 || attack_sum >= PEAK_X) begin
            lvl_d   = PEAK_X[LW-1:0];
            state_d = ST_DECAY;
          end else begin
            lvl_d = attack_sum[LW-1:0];
          end
        end
        ST_DECAY: begin
          if (env.decay_rate_in == '0 || lvl_x <= decay_floor) begin
            lvl_d   = sus_x[LW-1:0];
            state_d = ST_SUSTAIN;
          end else begin
            lvl_d = lvl_q - env.decay_rate_in;
          end
        end
        ST_SUSTAIN: begin
          lvl_d = sus_x[LW-1:0];
        end
        ST_RELEASE: begin
          if (env.release_rate_in == '0 || lvl_q <= env.release_rate_in) begin
            lvl_d   = '0;
            state_d = ST_IDLE;
          end else begin
            lvl_d = lvl_q - env.release_rate_in;
          end
        end
        default: begin
          lvl_d   = '0;
          state_d = ST_IDLE;
        end
      endcase
    end

    active_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= ST_IDLE;
      lvl_q       <= '0;
      gate_q      <= 1'b0;
      gate_prev_q <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      lvl_q       <= lvl_d;
      gate_q      <= gate_d;
      gate_prev_q <= gate_prev_d;
      active_q    <= active_d;
    end
  end

  assign env.vol_out    = lvl_q[LW-1:FRAC_BITS];
  assign env.active_out = active_q;

  lvl_within_peak: assert property (@(posedge clk_in) disable iff (!rst_in)
    lvl_q <= PEAK_X[LW-1:0]);

  state_is_legal: assert property (@(posedge clk_in) disable iff (!rst_in)
    state_q <= ST_RELEASE);

endmodule
